sliding_window_stream: RTL and testbench

SLIDING_WINDOW_STREAM -- requirements
Module: sliding_window_stream

---
 rtl/sliding_window_stream_if.sv | 29 ++
 rtl/sliding_window_stream.sv | 107 ++++++++++
 tb/tb_sliding_window_stream.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sliding_window_stream_if.sv
// Handshake bundle for sliding_window_stream: raster pixel input side and window output side.
interface sliding_window_stream_if #(
  parameter int KSIZE    = 3,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int BUS_SIZE = 25
);
  logic                              in_valid;
  logic                              in_ready;
  logic [BUS_SIZE-1:0]               in_data;
  logic                              in_sof;
  logic                              out_valid;
  logic                              out_ready;
  logic [KSIZE*KSIZE*BUS_SIZE-1:0]   out_window;
  logic [$clog2(WIDTH)-1:0]          out_x;
  logic [$clog2(HEIGHT)-1:0]         out_y;
  logic                              out_eof;
  logic                              sof_error;

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_window, out_x, out_y, out_eof, sof_error
  );

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_window, out_x, out_y, out_eof, sof_error
  );
endinterface

// File: rtl/sliding_window_stream.sv
// Streams a raster image and emits a KSIZE x KSIZE neighbourhood per pixel once the window is
// fully inside the frame; KSIZE-1 line buffers feed a register window, one-entry output stage.
module sliding_window_stream #(
  parameter int KSIZE    = 3,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int BUS_SIZE = 25
) (
  input logic                    clock,
  input logic                    reset_n,
  sliding_window_stream_if.slave bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(KSIZE - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(KSIZE - 1);

  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [XW-1:0]       cur_x;
  logic [YW-1:0]       cur_y;
  logic                accept;
  logic                emit;
  logic                last_pix;

  logic [BUS_SIZE-1:0] line_buf [KSIZE-1][WIDTH];
  logic [BUS_SIZE-1:0] win      [KSIZE][KSIZE];
  logic [BUS_SIZE-1:0] win_next [KSIZE][KSIZE];
  logic [BUS_SIZE-1:0] column   [KSIZE];
  logic [KSIZE*KSIZE*BUS_SIZE-1:0] win_flat;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // A start-of-frame pixel is always placed at (0,0), resynchronising the counters.
  assign cur_x    = bus.in_sof ? '0 : x;
  assign cur_y    = bus.in_sof ? '0 : y;
  assign last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign emit     = (cur_x >= X_FIRST) && (cur_y >= Y_FIRST);

  // Column entering the window: oldest row comes from the deepest line buffer.
  always_comb begin
    column[KSIZE-1] = bus.in_data;
    for (int r = 0; r < KSIZE-1; r++) begin
      column[r] = line_buf[KSIZE-2-r][cur_x];
    end
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE-1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
      win_next[r][KSIZE-1] = column[r];
    end
    win_flat = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        win_flat[(r*KSIZE+c)*BUS_SIZE +: BUS_SIZE] = win_next[r][c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      line_buf[0][cur_x] <= bus.in_data;
      for (int k = 1; k < KSIZE-1; k++) begin
        line_buf[k][cur_x] <= line_buf[k-1][cur_x];
      end
      win <= win_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x              <= '0;
      y              <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_window <= '0;
      bus.out_x      <= '0;
      bus.out_y      <= '0;
      bus.out_eof    <= 1'b0;
      bus.sof_error  <= 1'b0;
    end else if (accept) begin
      if (cur_x == X_LAST) begin
        x <= '0;
        y <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x <= cur_x + XW'(1);
        y <= cur_y;
      end
      if (bus.in_sof && (x != '0 || y != '0)) begin
        bus.sof_error <= 1'b1;
      end
      if (emit) begin
        bus.out_valid  <= 1'b1;
        bus.out_window <= win_flat;
        bus.out_x      <= cur_x;
        bus.out_y      <= cur_y;
        bus.out_eof    <= last_pix;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sliding_window_stream.sv
// Randomized self-checking bench for sliding_window_stream: a frame-image reference model
// predicts every window, and scenario tasks check counts, boundaries, stalls, resync and reset.
module tb_sliding_window_stream;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int B  = 8;
  localparam int WB = K*K*B;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sliding_window_stream_if #(.KSIZE(K), .WIDTH(W), .HEIGHT(H), .BUS_SIZE(B)) sw_if ();

  sliding_window_stream #(.KSIZE(K), .WIDTH(W), .HEIGHT(H), .BUS_SIZE(B)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (sw_if)
  );

  int vectors    = 0;
  int miscompares = 0;
  int ready_mode = 0;

  bit            model_on = 1'b0;
  int            mx, my, px, py;
  bit            acc;
  bit            exp_ovalid, exp_eof, exp_err;
  logic [WB-1:0] exp_win;
  logic [2:0]    exp_x, exp_y;
  logic [B-1:0]  img [H][W];

  int            consumed, eofs, accepts, first_valid_acc;
  logic [WB-1:0] win_log [$];
  logic [2:0]    log_x [$];
  logic [2:0]    log_y [$];

  always begin
    @(posedge clock);
    #1;
    if (ready_mode == 0) sw_if.out_ready = 1'b1;
    else if (ready_mode == 1) sw_if.out_ready = ($urandom_range(99) < 60);
  end

  // Reference model: at each falling edge compare the DUT against the predicted state, then
  // advance the prediction to what the coming rising edge must produce.
  always @(negedge clock) begin
    if (model_on) begin
      vectors++;
      if (sw_if.out_valid !== exp_ovalid) begin
        miscompares++;
        $display("[TB] FAIL mon_out_valid t=%0t got %b expected %b", $time, sw_if.out_valid, exp_ovalid);
      end
      vectors++;
      if (sw_if.in_ready !== (!exp_ovalid || sw_if.out_ready)) begin
        miscompares++;
        $display("[TB] FAIL mon_in_ready t=%0t got %b expected %b", $time, sw_if.in_ready, !exp_ovalid || sw_if.out_ready);
      end
      vectors++;
      if (sw_if.sof_error !== exp_err) begin
        miscompares++;
        $display("[TB] FAIL mon_sof_error t=%0t got %b expected %b", $time, sw_if.sof_error, exp_err);
      end
      if (exp_ovalid) begin
        vectors++;
        if ({sw_if.out_window, sw_if.out_x, sw_if.out_y, sw_if.out_eof} !== {exp_win, exp_x, exp_y, exp_eof}) begin
          miscompares++;
          $display("[TB] FAIL mon_window t=%0t got %h x%0d y%0d eof%b expected %h x%0d y%0d eof%b", $time,
                   sw_if.out_window, sw_if.out_x, sw_if.out_y, sw_if.out_eof, exp_win, exp_x, exp_y, exp_eof);
        end
      end
      if (sw_if.out_valid === 1'b1 && first_valid_acc < 0) first_valid_acc = accepts;
    end

    if (reset_n === 1'b0) begin
      mx = 0; my = 0;
      exp_ovalid = 1'b0; exp_eof = 1'b0; exp_err = 1'b0;
      exp_win = '0; exp_x = '0; exp_y = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      acc = sw_if.in_valid && (!exp_ovalid || sw_if.out_ready);
      if (exp_ovalid && sw_if.out_ready) begin
        consumed++;
        if (exp_eof) eofs++;
        win_log.push_back(exp_win);
        log_x.push_back(exp_x);
        log_y.push_back(exp_y);
      end
      if (acc) begin
        px = sw_if.in_sof ? 0 : mx;
        py = sw_if.in_sof ? 0 : my;
        if (sw_if.in_sof && (mx != 0 || my != 0)) exp_err = 1'b1;
        img[py][px] = sw_if.in_data;
        accepts++;
        if (px >= K-1 && py >= K-1) begin
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              exp_win[(r*K+c)*B +: B] = img[py-K+1+r][px-K+1+c];
          exp_x      = 3'(px);
          exp_y      = 3'(py);
          exp_eof    = (px == W-1) && (py == H-1);
          exp_ovalid = 1'b1;
        end else begin
          exp_ovalid = 1'b0;
        end
        mx = px + 1;
        my = py;
        if (mx == W) begin
          mx = 0;
          my = (py + 1 == H) ? 0 : py + 1;
        end
      end else if (sw_if.out_ready) begin
        exp_ovalid = 1'b0;
      end
    end
  end

  function automatic logic [B-1:0] pix_value(input int mode, input int px_i, input int py_i);
    if (mode == 0) return 8'(py_i*16 + px_i);
    if (mode == 1) return 8'(py_i*16 + px_i) | 8'h80;
    return 8'($urandom);
  endfunction

  task automatic clear_stats();
    consumed = 0; eofs = 0; accepts = 0; first_valid_acc = -1;
    win_log.delete(); log_x.delete(); log_y.delete();
  endtask

  task automatic push_pixel(input logic [B-1:0] d, input bit sof, input int gap_pct);
    bit done;
    for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
      sw_if.in_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    sw_if.in_valid = 1'b1;
    sw_if.in_data  = d;
    sw_if.in_sof   = sof;
    done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clock);
      done = sw_if.in_ready;
      @(posedge clock);
      #1;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL push_timeout got in_ready=%b expected 1 within 200 cycles", done);
    end
    sw_if.in_sof = 1'b0;
  endtask

  task automatic send_range(input int n, input int mode, input bit sof, input int gap_pct);
    for (int i = 0; i < n; i++) push_pixel(pix_value(mode, i % W, i / W), sof && (i == 0), gap_pct);
  endtask

  task automatic drain();
    sw_if.in_valid = 1'b0;
    ready_mode = 0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    sw_if.in_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    vectors++; if (sw_if.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b expected 0", sw_if.out_valid); end
    vectors++; if (sw_if.out_eof !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_eof got %b expected 0", sw_if.out_eof); end
    vectors++; if (sw_if.sof_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sof_error got %b expected 0", sw_if.sof_error); end
    vectors++; if (sw_if.out_window !== '0) begin miscompares++; $display("[TB] FAIL reset_out_window got %h expected 0", sw_if.out_window); end
    vectors++; if ({sw_if.out_x, sw_if.out_y} !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_out_xy got %0d,%0d expected 0,0", sw_if.out_x, sw_if.out_y); end
    vectors++; if (sw_if.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b expected 1", sw_if.in_ready); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_continuous();
    clear_stats();
    send_range(W*H, 0, 1'b1, 0);
    drain();
    vectors++; if (consumed != 24) begin miscompares++; $display("[TB] FAIL cont_count got %0d expected 24", consumed); end
    vectors++; if (eofs != 1) begin miscompares++; $display("[TB] FAIL cont_eofs got %0d expected 1", eofs); end
    vectors++; if (first_valid_acc != 19) begin miscompares++; $display("[TB] FAIL cont_first_latency got %0d expected 19", first_valid_acc); end
    vectors++;
    if (win_log.size() < 24) begin
      miscompares++; $display("[TB] FAIL cont_log_size got %0d expected 24", win_log.size());
    end else if (win_log[0][7:0] !== 8'h00 || win_log[0][71:64] !== 8'h22 || win_log[23][71:64] !== 8'h57 ||
                 log_x[23] !== 3'd7 || log_y[23] !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL cont_bounds got first %h/%h last %h at %0d,%0d expected 00/22 57 at 7,5",
               win_log[0][7:0], win_log[0][71:64], win_log[23][71:64], log_x[23], log_y[23]);
    end
  endtask

  task automatic test_stall();
    logic [WB-1:0] held;
    bit seen;
    clear_stats();
    ready_mode = 2;
    sw_if.out_ready = 1'b1;
    fork
      send_range(W*H, 0, 1'b1, 0);
      begin
        seen = 1'b0;
        for (int g = 0; g < 100 && !seen; g++) begin
          @(negedge clock);
          seen = (sw_if.out_valid === 1'b1);
        end
        vectors++;
        if (!seen) begin miscompares++; $display("[TB] FAIL stall_wait got no out_valid expected one within 100 cycles"); end
        @(posedge clock);
        #1 sw_if.out_ready = 1'b0;
        held = exp_win;
        repeat (5) begin
          @(negedge clock);
          vectors++;
          if (sw_if.in_ready !== 1'b0 || sw_if.out_window !== held) begin
            miscompares++;
            $display("[TB] FAIL stall_hold got in_ready=%b win=%h expected 0 %h", sw_if.in_ready, sw_if.out_window, held);
          end
        end
        @(posedge clock);
        #1 sw_if.out_ready = 1'b1;
        ready_mode = 0;
      end
    join
    drain();
    vectors++; if (consumed != 24) begin miscompares++; $display("[TB] FAIL stall_count got %0d expected 24", consumed); end
  endtask

  task automatic test_random_gaps();
    for (int pass = 0; pass < 2; pass++) begin
      clear_stats();
      ready_mode = 1;
      send_range(W*H, (pass == 0) ? 2 : 0, 1'b1, 30);
      drain();
      vectors++; if (consumed != 24) begin miscompares++; $display("[TB] FAIL gaps_count pass %0d got %0d expected 24", pass, consumed); end
      vectors++; if (eofs != 1) begin miscompares++; $display("[TB] FAIL gaps_eofs pass %0d got %0d expected 1", pass, eofs); end
    end
    vectors++;
    if (win_log.size() < 24 || win_log[23][71:64] !== 8'h57) begin
      miscompares++; $display("[TB] FAIL gaps_last got %0d windows expected 24 ending 0x57", win_log.size());
    end
  endtask

  task automatic test_sof_resync();
    bit clean;
    clear_stats();
    send_range(W*4 + 3, 0, 1'b1, 0);
    drain();
    vectors++; if (consumed != 13) begin miscompares++; $display("[TB] FAIL resync_pre_count got %0d expected 13", consumed); end
    vectors++; if (sw_if.sof_error !== 1'b0) begin miscompares++; $display("[TB] FAIL resync_pre_err got %b expected 0", sw_if.sof_error); end
    clear_stats();
    send_range(W*H, 1, 1'b1, 0);
    drain();
    vectors++; if (sw_if.sof_error !== 1'b1) begin miscompares++; $display("[TB] FAIL resync_err got %b expected 1", sw_if.sof_error); end
    vectors++; if (consumed != 24) begin miscompares++; $display("[TB] FAIL resync_count got %0d expected 24", consumed); end
    clean = (win_log.size() > 0) && (log_x[0] == 3'd2) && (log_y[0] == 3'd2) && (win_log[0][7:0] == 8'h80);
    for (int i = 0; i < win_log.size(); i++)
      for (int e = 0; e < K*K; e++)
        if (win_log[i][e*B+7] !== 1'b1) clean = 1'b0;
    vectors++; if (!clean) begin miscompares++; $display("[TB] FAIL resync_new_data got stale or misplaced window expected new-frame only from (2,2)"); end
  endtask

  task automatic test_reset_midframe();
    send_range(30, 0, 1'b1, 0);
    sw_if.in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    vectors++; if (sw_if.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_valid got %b expected 0", sw_if.out_valid); end
    vectors++; if (sw_if.sof_error !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_err got %b expected 0", sw_if.sof_error); end
    @(posedge clock);
    #1 clear_stats();
    send_range(W*H, 2, 1'b0, 0);
    drain();
    vectors++; if (first_valid_acc != 19) begin miscompares++; $display("[TB] FAIL mid_reset_latency got %0d expected 19", first_valid_acc); end
    vectors++; if (consumed != 24 || eofs != 1) begin miscompares++; $display("[TB] FAIL mid_reset_count got %0d/%0d expected 24/1", consumed, eofs); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    send_range(W*H, 0, 1'b1, 0);
    send_range(W*H, 1, 1'b1, 0);
    drain();
    vectors++; if (consumed != 48) begin miscompares++; $display("[TB] FAIL b2b_count got %0d expected 48", consumed); end
    vectors++; if (eofs != 2) begin miscompares++; $display("[TB] FAIL b2b_eofs got %0d expected 2", eofs); end
    vectors++;
    if (win_log.size() < 25 || win_log[24][7:0] !== 8'h80 || log_x[24] !== 3'd2 || log_y[24] !== 3'd2) begin
      miscompares++; $display("[TB] FAIL b2b_frame2_first got %0d windows expected frame-2 [0][0]=0x80 at 2,2", win_log.size());
    end
  endtask

  initial begin
    sw_if.in_valid  = 1'b0;
    sw_if.in_data   = '0;
    sw_if.in_sof    = 1'b0;
    sw_if.out_ready = 1'b1;
    clear_stats();
    test_reset();
    test_continuous();
    test_stall();
    test_random_gaps();
    test_sof_resync();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
